// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared rv32i pipe definitions for the fetch/memory bus arbiter.
package pipe_mem_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int BE_W     = XLEN / 8;
  localparam int STREAK_W = 4;

  localparam logic [BE_W-1:0] BE_ALL = {BE_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY_FETCH = 2'd1,
    BUSY_DATA  = 2'd2
  } arb_state_e;

  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] value);
    if (value == {STREAK_W{1'b1}}) begin
      return value;
    end else begin
      return value + {{(STREAK_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// Fetch, data and bus handshake bundle of the memory arbiter.
interface pipe_mem_arbiter_if;
  import pipe_mem_arbiter_pkg::*;

  logic            clear_i;
  logic            fetch_req_i;
  logic [XLEN-1:0] fetch_addr_i;
  logic            fetch_ack_o;
  logic [XLEN-1:0] fetch_data_o;
  logic            fetch_err_o;
  logic            fetch_stall_o;
  logic            data_req_i;
  logic            data_we_i;
  logic [XLEN-1:0] data_addr_i;
  logic [XLEN-1:0] data_wdata_i;
  logic [BE_W-1:0] data_be_i;
  logic            data_ack_o;
  logic [XLEN-1:0] data_rdata_o;
  logic            data_err_o;
  logic            data_stall_o;
  logic            bus_req_o;
  logic            bus_we_o;
  logic [XLEN-1:0] bus_addr_o;
  logic [XLEN-1:0] bus_wdata_o;
  logic [BE_W-1:0] bus_be_o;
  logic            bus_ack_i;
  logic [XLEN-1:0] bus_rdata_i;

  modport slave (
    input  clear_i, fetch_req_i, fetch_addr_i,
    input  data_req_i, data_we_i, data_addr_i, data_wdata_i, data_be_i,
    input  bus_ack_i, bus_rdata_i,
    output fetch_ack_o, fetch_data_o, fetch_err_o, fetch_stall_o,
    output data_ack_o, data_rdata_o, data_err_o, data_stall_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
  );

  modport master (
    output clear_i, fetch_req_i, fetch_addr_i,
    output data_req_i, data_we_i, data_addr_i, data_wdata_i, data_be_i,
    output bus_ack_i, bus_rdata_i,
    input  fetch_ack_o, fetch_data_o, fetch_err_o, fetch_stall_o,
    input  data_ack_o, data_rdata_o, data_err_o, data_stall_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
  );

endinterface

// File: rtl/pipe_mem_timeout.sv
// Loadable down-counter watchdog; expired flags an enabled count that has
// run down to zero.
module pipe_mem_timeout #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             clear,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;

  // Clear wins over load so a finished transaction never leaves a stale count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - WIDTH'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one memory bus between the fetch and memory stages with a bounded
// data streak, a transaction watchdog and flush-aware fetch discard.
module pipe_mem_arbiter
  import pipe_mem_arbiter_pkg::*;
#(
  parameter int DATA_STREAK_MAX = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input logic               clk_i,
  input logic               reset_ni,
  pipe_mem_arbiter_if.slave port
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD =
    (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : {TW{1'b0}};
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(DATA_STREAK_MAX);

  arb_state_e          state_r, state_s;
  logic [STREAK_W-1:0] streak_r, streak_s;
  logic                discard_r, discard_s;
  logic                bus_req_r, bus_req_s, bus_we_r, bus_we_s;
  logic [XLEN-1:0]     bus_addr_r, bus_addr_s, bus_wdata_r, bus_wdata_s;
  logic [BE_W-1:0]     bus_be_r, bus_be_s;
  logic                fetch_ack_r, fetch_ack_s, fetch_err_r, fetch_err_s;
  logic [XLEN-1:0]     fetch_data_r, fetch_data_s;
  logic                data_ack_r, data_ack_s, data_err_r, data_err_s;
  logic [XLEN-1:0]     data_rdata_r, data_rdata_s;
  logic                tmo_load_s, tmo_clear_s, tmo_expired_s;
  logic                done_s;
  logic [XLEN-1:0]     done_data_s;

  pipe_mem_timeout #(.WIDTH(TW)) u_timeout (
    .clk        (clk_i),
    .rst_n      (reset_ni),
    .load       (tmo_load_s),
    .load_value (TMO_LOAD),
    .enable     (state_r != IDLE),
    .clear      (tmo_clear_s),
    .expired    (tmo_expired_s)
  );

  // A bus ack in the expiry cycle still counts as a normal completion.
  assign done_s      = port.bus_ack_i || ((TIMEOUT_CYCLES > 0) && tmo_expired_s);
  assign done_data_s = port.bus_ack_i ? port.bus_rdata_i : {XLEN{1'b0}};

  // Next-state, arbitration and completion routing.
  always_comb begin
    state_s      = state_r;
    streak_s     = streak_r;
    discard_s    = discard_r;
    bus_req_s    = bus_req_r;
    bus_we_s     = bus_we_r;
    bus_addr_s   = bus_addr_r;
    bus_wdata_s  = bus_wdata_r;
    bus_be_s     = bus_be_r;
    fetch_ack_s  = 1'b0;
    fetch_err_s  = 1'b0;
    fetch_data_s = fetch_data_r;
    data_ack_s   = 1'b0;
    data_err_s   = 1'b0;
    data_rdata_s = data_rdata_r;
    tmo_load_s   = 1'b0;
    tmo_clear_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (port.data_req_i && ((streak_r < STREAK_LIMIT) || !port.fetch_req_i)) begin
          state_s     = BUSY_DATA;
          streak_s    = port.fetch_req_i ? streak_inc(streak_r) : {STREAK_W{1'b0}};
          bus_req_s   = 1'b1;
          bus_we_s    = port.data_we_i;
          bus_addr_s  = port.data_addr_i;
          bus_wdata_s = port.data_wdata_i;
          bus_be_s    = port.data_be_i;
          tmo_load_s  = 1'b1;
        end else if (port.fetch_req_i && !port.clear_i) begin
          state_s     = BUSY_FETCH;
          streak_s    = {STREAK_W{1'b0}};
          discard_s   = 1'b0;
          bus_req_s   = 1'b1;
          bus_we_s    = 1'b0;
          bus_addr_s  = port.fetch_addr_i;
          bus_wdata_s = {XLEN{1'b0}};
          bus_be_s    = BE_ALL;
          tmo_load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_FETCH: begin
        if (done_s) begin
          state_s     = IDLE;
          discard_s   = 1'b0;
          bus_req_s   = 1'b0;
          bus_we_s    = 1'b0;
          tmo_clear_s = 1'b1;
          // A flush in the completion cycle also kills the stale word.
          if (!(discard_r || port.clear_i)) begin
            fetch_ack_s  = 1'b1;
            fetch_err_s  = !port.bus_ack_i;
            fetch_data_s = done_data_s;
          end else begin
            fetch_ack_s = 1'b0;
          end
        end else begin
          discard_s = discard_r || port.clear_i;
        end
      end
      BUSY_DATA: begin
        if (done_s) begin
          state_s      = IDLE;
          bus_req_s    = 1'b0;
          bus_we_s     = 1'b0;
          tmo_clear_s  = 1'b1;
          data_ack_s   = 1'b1;
          data_err_s   = !port.bus_ack_i;
          data_rdata_s = done_data_s;
        end else begin
          state_s = BUSY_DATA;
        end
      end
      default: begin
        state_s   = IDLE;
        bus_req_s = 1'b0;
        bus_we_s  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bookkeeping and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      streak_r     <= {STREAK_W{1'b0}};
      discard_r    <= 1'b0;
      bus_req_r    <= 1'b0;
      bus_we_r     <= 1'b0;
      bus_addr_r   <= {XLEN{1'b0}};
      bus_wdata_r  <= {XLEN{1'b0}};
      bus_be_r     <= {BE_W{1'b0}};
      fetch_ack_r  <= 1'b0;
      fetch_err_r  <= 1'b0;
      fetch_data_r <= {XLEN{1'b0}};
      data_ack_r   <= 1'b0;
      data_err_r   <= 1'b0;
      data_rdata_r <= {XLEN{1'b0}};
    end else begin
      streak_r     <= streak_s;
      discard_r    <= discard_s;
      bus_req_r    <= bus_req_s;
      bus_we_r     <= bus_we_s;
      bus_addr_r   <= bus_addr_s;
      bus_wdata_r  <= bus_wdata_s;
      bus_be_r     <= bus_be_s;
      fetch_ack_r  <= fetch_ack_s;
      fetch_err_r  <= fetch_err_s;
      fetch_data_r <= fetch_data_s;
      data_ack_r   <= data_ack_s;
      data_err_r   <= data_err_s;
      data_rdata_r <= data_rdata_s;
    end
  end

  assign port.bus_req_o     = bus_req_r;
  assign port.bus_we_o      = bus_we_r;
  assign port.bus_addr_o    = bus_addr_r;
  assign port.bus_wdata_o   = bus_wdata_r;
  assign port.bus_be_o      = bus_be_r;
  assign port.fetch_ack_o   = fetch_ack_r;
  assign port.fetch_err_o   = fetch_err_r;
  assign port.fetch_data_o  = fetch_data_r;
  assign port.data_ack_o    = data_ack_r;
  assign port.data_err_o    = data_err_r;
  assign port.data_rdata_o  = data_rdata_r;
  assign port.fetch_stall_o = port.fetch_req_i & ~fetch_ack_r;
  assign port.data_stall_o  = port.data_req_i & ~data_ack_r;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized run scored against a transaction-level reference model.
`timescale 1ns/1ps
module tb_pipe_mem_arbiter;
  import pipe_mem_arbiter_pkg::*;

  localparam int TMO  = 8;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipe_mem_arbiter_if bif();

  pipe_mem_arbiter #(.DATA_STREAK_MAX(SMAX), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .port     (bif.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        freq;
    logic [31:0] faddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic        back;
    logic [31:0] brd;
    logic        xfst;
    logic        xdst;
    logic        xbreq;
    logic        xbwe;
    logic [31:0] xbaddr;
    logic [31:0] xbwd;
    logic [3:0]  xbbe;
    logic        xfack;
    logic [31:0] xfdata;
    logic        xdack;
  } vec_t;

  vec_t tbl [10];

  // reference model state
  int          m_owner;  // 0 none, 1 fetch, 2 data
  int          m_age;
  int          m_streak;
  bit          m_disc;
  logic        e_breq, e_bwe, e_fack, e_ferr, e_dack, e_derr;
  logic [31:0] e_baddr, e_bwd, e_fdata, e_drd;
  logic [3:0]  e_bbe;

  int s_wait;
  bit s_pend;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.clear_i      = 1'b0;
    bif.fetch_req_i  = 1'b0;
    bif.fetch_addr_i = 32'h0;
    bif.data_req_i   = 1'b0;
    bif.data_we_i    = 1'b0;
    bif.data_addr_i  = 32'h0;
    bif.data_wdata_i = 32'h0;
    bif.data_be_i    = 4'h0;
    bif.bus_ack_i    = 1'b0;
    bif.bus_rdata_i  = 32'h0;
  endtask

  // Bus slave: acks after a random number of busy cycles, never while idle.
  task automatic slave_step(input int max_wait);
    bif.bus_ack_i   = 1'b0;
    bif.bus_rdata_i = $urandom;
    if (!bif.bus_req_o) begin
      s_pend = 1'b0;
    end else begin
      if (!s_pend) begin
        s_pend = 1'b1;
        s_wait = $urandom_range(0, max_wait);
      end
      if (s_wait == 0) bif.bus_ack_i = 1'b1;
      else s_wait--;
    end
  endtask

  // Transaction-level model: who owns the bus, how long it has been busy.
  task automatic model_step();
    e_fack = 1'b0; e_ferr = 1'b0; e_dack = 1'b0; e_derr = 1'b0;
    if (m_owner != 0) begin
      m_age++;
      if (m_owner == 1 && bif.clear_i) m_disc = 1'b1;
      if (bif.bus_ack_i || m_age == TMO) begin
        if (m_owner == 2) begin
          e_dack = 1'b1;
          e_derr = !bif.bus_ack_i;
          e_drd  = bif.bus_ack_i ? bif.bus_rdata_i : 32'h0;
        end else if (!m_disc) begin
          e_fack  = 1'b1;
          e_ferr  = !bif.bus_ack_i;
          e_fdata = bif.bus_ack_i ? bif.bus_rdata_i : 32'h0;
        end
        m_owner = 0; m_disc = 1'b0; e_breq = 1'b0; e_bwe = 1'b0;
      end
    end else if (bif.data_req_i && (m_streak < SMAX || !bif.fetch_req_i)) begin
      m_streak = bif.fetch_req_i ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
      m_owner = 2; m_age = 0;
      e_breq = 1'b1; e_bwe = bif.data_we_i; e_baddr = bif.data_addr_i;
      e_bwd = bif.data_wdata_i; e_bbe = bif.data_be_i;
    end else if (bif.fetch_req_i && !bif.clear_i) begin
      m_streak = 0; m_owner = 1; m_age = 0; m_disc = 1'b0;
      e_breq = 1'b1; e_bwe = 1'b0; e_baddr = bif.fetch_addr_i; e_bbe = 4'hF;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          grants[$];
    int          exp_grants[6];
    logic        prev_req;
    int          busy;
    logic [105:0] act_v, exp_v;

    //                freq faddr          dreq  dwe   daddr          dwd            dbe   back  brd            fst   dst   breq  bwe   baddr          bwd            bbe   fack  fdata          dack
    tbl[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 1'b0, 32'h0,         1'b0};
    tbl[1] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 1'b0, 32'h0,         1'b0};
    tbl[2] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 1'b0, 32'h0,         1'b0};
    tbl[3] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[4] = '{1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[6] = '{1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 1'b1, 32'h55AA_55AA, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0,         4'h3, 1'b0, 32'hDEAD_BEEF, 1'b1};
    tbl[7] = '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[8] = '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'hF, 1'b1, 32'hCAFE_F00D, 1'b0};
    tbl[9] = '{1'b0, 32'h0000_0104, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D, 1'b0};

    // reset state
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 128'({bif.bus_req_o, bif.bus_we_o, bif.bus_addr_o, bif.bus_be_o,
                               bif.fetch_ack_o, bif.fetch_err_o, bif.fetch_data_o,
                               bif.data_ack_o, bif.data_err_o, bif.data_rdata_o}), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // table-driven directed vectors
    for (int i = 0; i < 10; i++) begin
      bif.fetch_req_i  = tbl[i].freq;
      bif.fetch_addr_i = tbl[i].faddr;
      bif.data_req_i   = tbl[i].dreq;
      bif.data_we_i    = tbl[i].dwe;
      bif.data_addr_i  = tbl[i].daddr;
      bif.data_wdata_i = tbl[i].dwd;
      bif.data_be_i    = tbl[i].dbe;
      bif.bus_ack_i    = tbl[i].back;
      bif.bus_rdata_i  = tbl[i].brd;
      #1;
      chk($sformatf("vec%0d_stall", i), 128'({bif.fetch_stall_o, bif.data_stall_o}),
          128'({tbl[i].xfst, tbl[i].xdst}));
      tick();
      chk($sformatf("vec%0d_out", i),
          128'({bif.bus_req_o, bif.bus_we_o, bif.bus_addr_o, bif.bus_be_o,
                bif.fetch_ack_o, bif.fetch_data_o, bif.data_ack_o}),
          128'({tbl[i].xbreq, tbl[i].xbwe, tbl[i].xbaddr, tbl[i].xbbe,
                tbl[i].xfack, tbl[i].xfdata, tbl[i].xdack}));
      if (tbl[i].xbwe) chk($sformatf("vec%0d_wdata", i), 128'(bif.bus_wdata_o), 128'(tbl[i].xbwd));
    end
    idle_inputs();
    tick();

    // data streak limit: D D D D F D
    exp_grants = '{2, 2, 2, 2, 1, 2};
    bif.fetch_req_i = 1'b1; bif.fetch_addr_i = 32'h180;
    bif.data_req_i  = 1'b1; bif.data_we_i = 1'b0; bif.data_addr_i = 32'h280; bif.data_be_i = 4'hF;
    prev_req = bif.bus_req_o;
    for (int cyc = 0; cyc < 100 && grants.size() < 6; cyc++) begin
      tick();
      if (bif.bus_req_o && !prev_req) grants.push_back((bif.bus_addr_o[11:8] == 4'h2) ? 2 : 1);
      prev_req = bif.bus_req_o;
      bif.bus_ack_i   = bif.bus_req_o;
      bif.bus_rdata_i = $urandom | 32'h1;
      if (bif.fetch_ack_o) bif.fetch_req_i = 1'b0;
    end
    chk("streak_count", 128'(grants.size()), 128'(6));
    for (int g = 0; g < 6; g++) begin
      if (g < grants.size()) chk($sformatf("streak_grant%0d", g), 128'(grants[g]), 128'(exp_grants[g]));
    end
    bif.data_req_i = 1'b0;
    tick();
    idle_inputs();
    tick();

    // flush during a fetch: transaction completes, ack suppressed
    bif.fetch_req_i = 1'b1; bif.fetch_addr_i = 32'h300;
    tick();
    chk("clr_grant", 128'({bif.bus_req_o, bif.bus_addr_o}), 128'({1'b1, 32'h300}));
    bif.clear_i = 1'b1; bif.fetch_addr_i = 32'h304;
    tick();
    bif.clear_i = 1'b0;
    chk("clr_hold", 128'({bif.bus_req_o, bif.bus_addr_o, bif.fetch_ack_o}), 128'({1'b1, 32'h300, 1'b0}));
    tick();
    chk("clr_wait", 128'({bif.bus_req_o, bif.fetch_ack_o}), 128'({1'b1, 1'b0}));
    bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'h1111_1111;
    tick();
    bif.bus_ack_i = 1'b0;
    chk("clr_done", 128'({bif.bus_req_o, bif.fetch_ack_o}), 128'({1'b0, 1'b0}));
    tick();
    chk("clr_next", 128'({bif.bus_req_o, bif.bus_addr_o, bif.fetch_ack_o}), 128'({1'b1, 32'h304, 1'b0}));
    bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'h2222_2222;
    tick();
    bif.bus_ack_i = 1'b0; bif.fetch_req_i = 1'b0;
    chk("clr_next_ack", 128'({bif.fetch_ack_o, bif.fetch_err_o, bif.fetch_data_o}), 128'({1'b1, 1'b0, 32'h2222_2222}));
    tick();
    chk("clr_next_pulse", 128'(bif.fetch_ack_o), 128'(0));

    // load timeout
    bif.data_req_i = 1'b1; bif.data_we_i = 1'b0; bif.data_addr_i = 32'h400; bif.data_be_i = 4'hF;
    tick();
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bif.bus_req_o) break;
      busy++;
      tick();
    end
    bif.data_req_i = 1'b0;
    chk("tmo_busy_cycles", 128'(busy), 128'(TMO));
    chk("tmo_ack", 128'({bif.bus_req_o, bif.data_ack_o, bif.data_err_o, bif.data_rdata_o}),
        128'({1'b0, 1'b1, 1'b1, 32'h0}));
    tick();
    chk("tmo_pulse", 128'({bif.data_ack_o, bif.data_err_o}), 128'(0));

    // bus ack in the expiry cycle wins
    bif.data_req_i = 1'b1; bif.data_addr_i = 32'h404;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("tie_still_busy", 128'(bif.bus_req_o), 128'(1));
    bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'h0BAD_F00D;
    tick();
    bif.bus_ack_i = 1'b0; bif.data_req_i = 1'b0;
    chk("tie_ack", 128'({bif.bus_req_o, bif.data_ack_o, bif.data_err_o, bif.data_rdata_o}),
        128'({1'b0, 1'b1, 1'b0, 32'h0BAD_F00D}));
    tick();

    // asynchronous reset in the middle of a data transaction
    bif.fetch_req_i = 1'b1; bif.fetch_addr_i = 32'h500;
    bif.data_req_i  = 1'b1; bif.data_addr_i  = 32'h600;
    tick();
    chk("rst_busy", 128'({bif.bus_req_o, bif.bus_addr_o}), 128'({1'b1, 32'h600}));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async", 128'({bif.bus_req_o, bif.fetch_ack_o, bif.data_ack_o}), 128'(0));
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rst_state", 128'(dut.state_r), 128'(IDLE));
    chk("rst_streak", 128'(dut.streak_r), 128'(0));

    // randomized run against the reference model
    m_owner = 0; m_age = 0; m_streak = 0; m_disc = 1'b0;
    e_breq = 1'b0; e_bwe = 1'b0; e_fack = 1'b0; e_ferr = 1'b0; e_dack = 1'b0; e_derr = 1'b0;
    e_baddr = 32'h0; e_bwd = 32'h0; e_fdata = 32'h0; e_drd = 32'h0; e_bbe = 4'h0;
    s_pend = 1'b0; s_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      act_v = {bif.bus_req_o, bif.bus_we_o, bif.bus_addr_o, bif.bus_be_o,
               bif.fetch_ack_o, bif.fetch_err_o, bif.fetch_data_o,
               bif.data_ack_o, bif.data_err_o, bif.data_rdata_o};
      exp_v = {e_breq, e_bwe, e_baddr, e_bbe, e_fack, e_ferr, e_fdata, e_dack, e_derr, e_drd};
      chk($sformatf("rand%0d_out", cyc), 128'(act_v), 128'(exp_v));
      if (e_breq && e_bwe) chk($sformatf("rand%0d_wdata", cyc), 128'(bif.bus_wdata_o), 128'(e_bwd));

      if (bif.fetch_ack_o) begin
        bif.fetch_req_i = 1'b0;
      end else if (!bif.fetch_req_i && $urandom_range(0, 2) == 0) begin
        bif.fetch_req_i = 1'b1; bif.fetch_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      bif.clear_i = ($urandom_range(0, 15) == 0);
      if (bif.clear_i) bif.fetch_addr_i = $urandom & 32'hFFFF_FFFC;
      if (bif.data_ack_o) begin
        bif.data_req_i = 1'b0;
      end else if (!bif.data_req_i && $urandom_range(0, 2) == 0) begin
        bif.data_req_i   = 1'b1;
        bif.data_we_i    = $urandom_range(0, 1);
        bif.data_addr_i  = $urandom;
        bif.data_wdata_i = $urandom;
        bif.data_be_i    = 4'($urandom_range(1, 15));
      end else if (bif.data_req_i && $urandom_range(0, 40) == 0) begin
        bif.data_req_i = 1'b0;
      end
      slave_step(10);
      #1;
      chk($sformatf("rand%0d_stall", cyc), 128'({bif.fetch_stall_o, bif.data_stall_o}),
          128'({bif.fetch_req_i & ~e_fack, bif.data_req_i & ~e_dack}));
      model_step();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
